// File: rtl/clock_pkg.sv
// Shared types and constants for the time-of-day clock and its set controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package clock_pkg;

    // The enum encoding doubles as the edit_field value seen by the display.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;

    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;

    // Mode button walks RUN -> SET_H -> SET_M -> SET_S -> RUN.
    function automatic state_t next_mode(input state_t cur);
        state_t nxt;
        case (cur)
            RUN:     nxt = SET_H;
            SET_H:   nxt = SET_M;
            SET_M:   nxt = SET_S;
            default: nxt = RUN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) up/down counter with carry on the MAX->0 increment.
// Latency: value updates one edge after inc/dec/clr; carry is combinational.
// Backpressure: none; inc and dec together cancel, out-of-range values self-clear.
module wrap_counter #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned MAX   = 59
) (
    input  logic             regular_clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [WIDTH-1:0] value,
    output logic             carry
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic up;
    logic down;
    logic out_of_range;

    assign up           = inc & ~dec;
    assign down         = dec & ~inc;
    assign out_of_range = (value > MAX_V);
    // Carry only on a genuine wrap, not when the field is being cleared or repaired.
    assign carry        = up & ~clr & ~out_of_range & (value == MAX_V);

    // Counter register: repair, clear, then wrap in either direction.
    always_ff @(posedge regular_clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (out_of_range || clr) begin
            value <= '0;
        end else if (up) begin
            value <= (value == MAX_V) ? '0 : value + WIDTH'(1);
        end else if (down) begin
            value <= (value == '0) ? MAX_V : value - WIDTH'(1);
        end
    end

endmodule

// File: rtl/time_set_controller.sv
// hh:mm:ss time-of-day keeper with a mode FSM for editing hours/minutes/seconds.
// Latency: all outputs registered; a pulse sampled on edge N is visible after edge N.
// Backpressure: none; every pulse is consumed the cycle it arrives. Optional macro TIME_SET_TIMEOUT_EN adds edit auto-exit.
module time_set_controller
    import clock_pkg::*;
#(
    parameter int unsigned TIMEOUT_SECS = 10,
    parameter int unsigned HOUR_MAX     = 23
) (
    input  logic              regular_clk,
    input  logic              reset,
    input  logic              sec_tick,
    input  logic              mode_pulse,
    input  logic              inc_pulse,
    input  logic              dec_pulse,
    output logic [HOUR_W-1:0] hours,
    output logic [MIN_W-1:0]  minutes,
    output logic [SEC_W-1:0]  seconds,
    output logic [1:0]        edit_field,
    output logic              day_wrap
);

    state_t state;
    state_t state_next;

    logic run;
    logic edit_inc;
    logic edit_dec;
    logic timeout_hit;

    logic sec_inc, sec_dec, sec_carry;
    logic min_inc, min_dec, min_carry;
    logic hr_inc,  hr_dec,  hr_carry;

    assign run = (state == RUN);

    // A mode press in the same cycle swallows any inc/dec press.
    assign edit_inc = inc_pulse & ~mode_pulse;
    assign edit_dec = dec_pulse & ~mode_pulse;

    // In RUN the fields chain via carries; in SET only the selected field moves.
    assign sec_inc = run ? sec_tick  : ((state == SET_S) & edit_inc);
    assign min_inc = run ? sec_carry : ((state == SET_M) & edit_inc);
    assign hr_inc  = run ? min_carry : ((state == SET_H) & edit_inc);
    assign sec_dec = (state == SET_S) & edit_dec;
    assign min_dec = (state == SET_M) & edit_dec;
    assign hr_dec  = (state == SET_H) & edit_dec;

    wrap_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
        .regular_clk (regular_clk),
        .reset       (reset),
        .inc         (sec_inc),
        .dec         (sec_dec),
        .clr         (1'b0),
        .value       (seconds),
        .carry       (sec_carry)
    );

    wrap_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
        .regular_clk (regular_clk),
        .reset       (reset),
        .inc         (min_inc),
        .dec         (min_dec),
        .clr         (1'b0),
        .value       (minutes),
        .carry       (min_carry)
    );

    wrap_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hr (
        .regular_clk (regular_clk),
        .reset       (reset),
        .inc         (hr_inc),
        .dec         (hr_dec),
        .clr         (1'b0),
        .value       (hours),
        .carry       (hr_carry)
    );

`ifdef TIME_SET_TIMEOUT_EN
    localparam logic [5:0] TIMEOUT_LAST = 6'(TIMEOUT_SECS - 1);

    logic [5:0] idle_cnt;
    logic       any_pulse;

    assign any_pulse   = mode_pulse | inc_pulse | dec_pulse;
    // Fire on the tick that would bring the idle count up to TIMEOUT_SECS.
    assign timeout_hit = ~run & sec_tick & ~any_pulse & (idle_cnt == TIMEOUT_LAST);

    // Idle seconds while editing; held at zero in RUN and restarted by any press.
    always_ff @(posedge regular_clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (run || any_pulse || timeout_hit) begin
            idle_cnt <= '0;
        end else if (sec_tick) begin
            idle_cnt <= idle_cnt + 6'd1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = |6'(TIMEOUT_SECS);
`endif

    // Mode FSM next state: mode press steps the field, timeout drops back to RUN.
    always_comb begin
        state_next = state;
        if (mode_pulse) begin
            state_next = next_mode(state);
        end else if (timeout_hit) begin
            state_next = RUN;
        end
    end

    // Mode FSM state register.
    always_ff @(posedge regular_clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Day rollover pulse: only the hours carry from a running clock marks midnight.
    always_ff @(posedge regular_clk or posedge reset) begin
        if (reset) begin
            day_wrap <= 1'b0;
        end else begin
            day_wrap <= run & hr_carry;
        end
    end

    assign edit_field = state;

endmodule
